// File: rtl/cp_strip_pkg.sv
// Shared definitions for the cyclic-prefix strip stage: default frame
// geometry, counter widths and the framing FSM state encoding.
package cp_strip_pkg;

  // Default OFDM geometry
  localparam int unsigned NFFT_DEF = 64;
  localparam int unsigned NCP_DEF  = 16;
  localparam int unsigned NSYM_DEF = 100;

  // Sample counter and symbol counter widths
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SYM_W = 8;

  // Framing FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SYM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sym_pos_cnt.sv
// Modulo-LEN symbol position counter with a symbol counter that advances on
// every wrap. pos_cur is the position of the sample being consumed this cycle:
// ld0 forces it to zero (start of symbol 0), otherwise it is the stored count.
module sym_pos_cnt
  import cp_strip_pkg::*;
#(
  parameter int unsigned LEN = NCP_DEF + NFFT_DEF,
  parameter int unsigned PW  = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld0,
  output logic [PW-1:0]    pos_cur,
  output logic [SYM_W-1:0] sym
);

  localparam logic [PW-1:0] POS_LAST = PW'(LEN - 1);

  logic [PW-1:0] pos_q;
  logic          wrap;

  assign pos_cur = ld0 ? '0 : pos_q;
  assign wrap    = en && (pos_cur == POS_LAST);

  // Advance position per consumed sample; wrap bumps the symbol count
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pos_q <= '0;
      sym   <= '0;
    end else if (en) begin
      pos_q <= wrap ? '0 : pos_cur + 1'b1;
      if (wrap) begin
        sym <= sym + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp_strip.sv
// Cyclic-prefix strip: waits for the symbol-0 boundary index, then forwards
// NFFT samples per symbol (with start/end markers) for NSYM symbols, discarding
// the cyclic prefix, and pulses frame_done before re-arming.
// Optional build macro CP_STRIP_BACKOFF_EN: the FFT window starts BACKOFF
// samples early, inside the cyclic prefix, to tolerate late timing estimates.
module cp_strip
  import cp_strip_pkg::*;
#(
  parameter int unsigned DW      = 12,
  parameter int unsigned IW      = 10,
  parameter int unsigned NFFT    = NFFT_DEF,
  parameter int unsigned NCP     = NCP_DEF,
  parameter int unsigned NSYM    = NSYM_DEF,
  parameter int unsigned BACKOFF = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] di_re,
  input  logic [DW-1:0] di_im,
  input  logic          di_vld,
  input  logic [IW-1:0] max_indx,
  input  logic          max_indx_vld,
  output logic [DW-1:0] do_re,
  output logic [DW-1:0] do_im,
  output logic          do_vld,
  output logic          do_sos,
  output logic          do_eos,
  output logic [7:0]    sym_idx,
  output logic          frame_done,
  output logic          sync_late
);

  localparam int unsigned SYM_LEN = NCP + NFFT;
  localparam int unsigned PW      = $clog2(SYM_LEN);
`ifdef CP_STRIP_BACKOFF_EN
  localparam int unsigned S = NCP - BACKOFF;
`else
  // Window starts right after the prefix; BACKOFF has no effect here
  localparam int unsigned S = NCP + 0 * BACKOFF;
`endif
  localparam logic [PW-1:0]    WIN_FIRST = PW'(S);
  localparam logic [PW-1:0]    WIN_LAST  = PW'(S + NFFT - 1);
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(NSYM - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   samp_cnt;
  logic [CNT_W-1:0]   off_q;
  logic [CNT_W-1:0]   off_in;
  logic               off_ld;
  logic               late_p0;
  logic               start_p0;
  logic               cnt_en;
  logic               cnt_clr;
  logic [PW-1:0]      pos_cur;
  logic [SYM_W-1:0]   sym_cnt;
  logic               fwd_p0;
  logic               sos_p0;
  logic               eos_p0;
  logic               last_p0;

  assign off_in  = CNT_W'(max_indx);
  assign cnt_clr = (state_q == ST_DONE);

  sym_pos_cnt #(
    .LEN (SYM_LEN),
    .PW  (PW)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .ld0     (start_p0),
    .pos_cur (pos_cur),
    .sym     (sym_cnt)
  );

  // Boundary capture / symbol-0 detection and counter enable
  always_comb begin
    off_ld   = 1'b0;
    late_p0  = 1'b0;
    start_p0 = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (max_indx_vld) begin
          off_ld = 1'b1;
          if (off_in < samp_cnt) begin
            late_p0 = 1'b1;
          end else if (di_vld && (off_in == samp_cnt)) begin
            start_p0 = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (di_vld && (samp_cnt == off_q)) begin
          start_p0 = 1'b1;
        end
      end
      ST_SYM: begin
        cnt_en = di_vld;
      end
      default: begin
      end
    endcase
    if (start_p0) begin
      cnt_en = 1'b1;
    end
  end

  assign fwd_p0  = cnt_en && (pos_cur >= WIN_FIRST) && (pos_cur <= WIN_LAST);
  assign sos_p0  = fwd_p0 && (pos_cur == WIN_FIRST);
  assign eos_p0  = fwd_p0 && (pos_cur == WIN_LAST);
  assign last_p0 = eos_p0 && (sym_cnt == SYM_LAST);

  // Next-state: arm, lock to boundary, finish frame after last window
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (max_indx_vld && !late_p0) begin
          state_d = start_p0 ? ST_SYM : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (start_p0) begin
          state_d = ST_SYM;
        end
      end
      ST_SYM:  state_d = state_q;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (last_p0) begin
      state_d = ST_DONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating sample index and latched boundary offset
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt <= '0;
      off_q    <= '0;
    end else begin
      if (di_vld) begin
        samp_cnt <= sat_inc(samp_cnt);
      end
      if (off_ld) begin
        off_q <= off_in;
      end
    end
  end

  // ---- stage p0 -> p1: registered outputs, data held between strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      do_re      <= '0;
      do_im      <= '0;
      do_vld     <= 1'b0;
      do_sos     <= 1'b0;
      do_eos     <= 1'b0;
      sym_idx    <= '0;
      frame_done <= 1'b0;
      sync_late  <= 1'b0;
    end else begin
      do_vld     <= fwd_p0;
      do_sos     <= sos_p0;
      do_eos     <= eos_p0;
      sync_late  <= late_p0;
      frame_done <= (state_q == ST_DONE);
      if (fwd_p0) begin
        do_re   <= di_re;
        do_im   <= di_im;
        sym_idx <= sym_cnt;
      end else if (state_q == ST_DONE) begin
        sym_idx <= '0;
      end
    end
  end

endmodule
